uart_prog_loader: RTL

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives a SYNC/LEN/DATA/CSUM frame from a UART receiver,
// writes the payload to program memory and replies with ACK or NAK.
module uart_prog_loader #(
    parameter int          ADDR_WIDTH     = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_done,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_done,
    output logic [7:0]            tx_byte,
    output logic                  tx_send,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  busy,
    output logic                  loaded,
    output logic                  error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_SEND, S_WAIT_TX
    } state_t;

    state_t                r_state;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [15:0]           r_cnt;
    logic [7:0]            r_sum;
    logic [TW-1:0]         r_tmo;
    logic                  r_ack;
    logic [7:0]            r_tx_byte;
    logic                  r_tx_send;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_data;
    logic                  r_loaded;
    logic                  r_error;

    logic w_active;
    logic w_timeout;

    // The inter-byte watchdog only runs while a frame is being received.
    assign w_active  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
    // A byte arriving on the expiry cycle still counts, so rx_done masks the timeout.
    assign w_timeout = w_active && !rx_done && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_hi   <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
            r_ack      <= 1'b0;
            r_tx_byte  <= '0;
            r_tx_send  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_loaded   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_tx_send <= 1'b0;
            r_mem_we  <= 1'b0;
            r_error   <= 1'b0;

            if (w_active)
                r_tmo <= rx_done ? '0 : r_tmo + TW'(1);
            else
                r_tmo <= '0;

            if (w_timeout) begin
                r_state <= S_IDLE;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (rx_done && rx_byte == SYNC_BYTE) begin
                        r_state  <= S_LEN_HI;
                        r_loaded <= 1'b0;
                        r_sum    <= '0;
                        r_cnt    <= '0;
                    end
                    S_LEN_HI: if (rx_done) begin
                        r_len_hi <= rx_byte;
                        r_state  <= S_LEN_LO;
                    end
                    S_LEN_LO: if (rx_done) begin
                        r_len   <= {r_len_hi, rx_byte};
                        r_state <= ({r_len_hi, rx_byte} == 16'd0) ? S_CSUM : S_DATA;
                    end
                    S_DATA: if (rx_done) begin
                        r_mem_we   <= 1'b1;
                        r_mem_data <= rx_byte;
                        r_mem_addr <= ADDR_WIDTH'(r_cnt);
                        r_sum      <= r_sum + rx_byte;
                        r_cnt      <= r_cnt + 16'd1;
                        if (r_cnt == r_len - 16'd1)
                            r_state <= S_CSUM;
                    end
                    S_CSUM: if (rx_done) begin
                        r_ack     <= (rx_byte == r_sum);
                        r_tx_byte <= (rx_byte == r_sum) ? ACK_BYTE : NAK_BYTE;
                        r_tx_send <= 1'b1;
                        r_state   <= S_SEND;
                    end
                    S_SEND: r_state <= S_WAIT_TX;
                    S_WAIT_TX: if (tx_done) begin
                        r_state  <= S_IDLE;
                        r_loaded <= r_ack;
                        r_error  <= !r_ack;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_byte  = r_tx_byte;
    assign tx_send  = r_tx_send;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign busy     = (r_state != S_IDLE);
    assign loaded   = r_loaded;
    assign error    = r_error;

endmodule
